// File: rtl/imem_loader_if.sv
// Byte-stream loader bus: start/length command, byte source handshake,
// instruction-memory write port and loader status towards the core.
interface imem_loader_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [7:0]        length;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;

    // Host / byte source side
    modport master (
        output start, length, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  core_rst, busy, done, err
    );

    // Loader side
    modport slave (
        input  start, length, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output core_rst, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian 32-bit words from a
// byte stream, writes them to consecutive word addresses, and holds the
// processor in reset until the whole program has been written.
module imem_loader #(
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_W      = 9
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [7:0]        r_len;
    logic [7:0]        r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;
    logic              r_byte_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_len_ok;
    logic              w_hs;
    logic [7:0]        w_word_nxt;

    assign w_len_ok   = (bus.length != 8'd0) &&
                        ({24'd0, bus.length} <= 32'(DEPTH_WORDS));
    // byte_ready is only ever high in LOAD, so this is the transfer condition
    assign w_hs       = bus.byte_valid & r_byte_ready;
    assign w_word_nxt = r_word_idx + 8'd1;

    // Collect bytes 0..2 of the current word; byte 3 goes straight to wdata
    always_ff @(posedge clk) begin
        if (w_hs) begin
            case (r_byte_idx)
                2'd0:    r_word[7:0]   <= bus.byte_data;
                2'd1:    r_word[15:8]  <= bus.byte_data;
                2'd2:    r_word[23:16] <= bus.byte_data;
                default: r_word        <= r_word;
            endcase
        end
    end

    // Loader FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_len        <= 8'd0;
            r_word_idx   <= 8'd0;
            r_byte_idx   <= 2'd0;
            r_byte_ready <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_core_rst   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_len_ok) begin
                            r_len        <= bus.length;
                            r_word_idx   <= 8'd0;
                            r_byte_idx   <= 2'd0;
                            r_err        <= 1'b0;
                            r_core_rst   <= 1'b1;
                            r_busy       <= 1'b1;
                            r_byte_ready <= 1'b1;
                            r_state      <= LOAD;
                        end else begin
                            // Bad length: flag it, leave everything else alone
                            r_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_hs) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_imem_wdata <= {bus.byte_data, r_word};
                            r_imem_addr  <= ADDR_W'({r_word_idx, 2'b00});
                            r_imem_we    <= 1'b1;
                            r_byte_ready <= 1'b0;
                            r_state      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_imem_we  <= 1'b0;
                    r_word_idx <= w_word_nxt;
                    if (w_word_nxt == r_len) begin
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b0;
                        r_state    <= DONE;
                    end else begin
                        r_byte_ready <= 1'b1;
                        r_state      <= LOAD;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.core_rst   = r_core_rst;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load/reject vectors, a write scoreboard
// fed as bytes are driven, and hand-written reset-abort sequence.
module tb_imem_loader;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 128;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bif ();

    imem_loader #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    // len, random valid gaps, data mode (0 fixed,1 random,2 byte count), poke start, expect reject
    typedef struct {
        int len;
        bit rnd;
        int mode;
        bit poke;
        bit exp_err;
    } vec_t;

    wr_t               sb_q[$];
    int                n_checks = 0;
    int                n_err    = 0;
    int                n_writes = 0;
    int                n_done   = 0;
    int                loads_expected = 0;
    bit                hold_on  = 1'b0;
    bit                busy_win = 1'b0;
    logic              exp_core_rst = 1'b1;
    logic [ADDR_W-1:0] exp_last_addr = '0;
    logic [31:0]       exp_last_data = 32'd0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Write monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        wr_t e;
        if (bif.done) n_done++;
        if (busy_win) check("busy_during_load", bif.busy, 1);
        if (bif.imem_we) begin
            n_writes++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected at %0t",
                         bif.imem_addr, bif.imem_wdata, $time);
            end else begin
                e = sb_q.pop_front();
                check("imem_addr", bif.imem_addr, e.addr);
                check("imem_wdata", bif.imem_wdata, e.data);
                check("addr_bound", bif.imem_addr > 9'h1FC, 0);
                exp_last_addr = e.addr;
                exp_last_data = e.data;
            end
        end else if (hold_on) begin
            check("hold_addr", bif.imem_addr, exp_last_addr);
            check("hold_wdata", bif.imem_wdata, exp_last_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        if (rnd) begin
            int s;
            s = $urandom_range(0, 3);
            if (s > 0) begin
                bif.byte_valid = 1'b0;
                bif.byte_data  = 8'($urandom);
                repeat (s) tick();
            end
        end
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        n = 0;
        while (!bif.byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bif.byte_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL byte_ready_timeout: got 0 after %0d cycles, required 1", n);
        end
        tick();
    endtask

    task automatic do_load(input int len, input bit rnd, input int mode, input bit poke);
        logic [7:0]  b;
        logic [31:0] w;
        logic [7:0]  fixed_bytes [4];
        fixed_bytes[0] = 8'h13;
        fixed_bytes[1] = 8'h05;
        fixed_bytes[2] = 8'h50;
        fixed_bytes[3] = 8'h00;
        w = 32'd0;
        bif.start  = 1'b1;
        bif.length = 8'(len);
        tick();
        bif.start  = 1'b0;
        bif.length = 8'($urandom);
        check("busy_after_start", bif.busy, 1);
        check("core_rst_after_start", bif.core_rst, 1);
        check("err_cleared_on_start", bif.err, 0);
        exp_core_rst = 1'b1;
        busy_win = 1'b1;
        for (int wi = 0; wi < len; wi++) begin
            for (int k = 0; k < 4; k++) begin
                if (mode == 0)      b = fixed_bytes[k];
                else if (mode == 1) b = 8'($urandom);
                else                b = 8'((wi * 4 + k) & 255);
                w[8*k +: 8] = b;
                if (k == 3) sb_q.push_back('{addr: ADDR_W'(wi * 4), data: w});
                send_byte(b, rnd);
            end
            if (poke && wi == 0) begin
                bif.byte_valid = 1'b0;
                bif.start  = 1'b1;
                bif.length = 8'd0;
                tick();
                bif.length = 8'd1;
                tick();
                bif.start  = 1'b0;
            end
        end
        bif.byte_valid = 1'b0;
        check("we_one_after_last_byte", bif.imem_we, 1);
        tick();
        busy_win = 1'b0;
        check("done_two_after_last_byte", bif.done, 1);
        check("core_rst_released", bif.core_rst, 0);
        check("busy_in_done", bif.busy, 0);
        exp_core_rst = 1'b0;
        tick();
        check("done_single_pulse", bif.done, 0);
        check("core_rst_stays_low", bif.core_rst, 0);
        check("err_after_load", bif.err, 0);
        loads_expected++;
    endtask

    task automatic do_reject(input int len);
        bif.start  = 1'b1;
        bif.length = 8'(len);
        tick();
        bif.start  = 1'b0;
        check("err_on_bad_length", bif.err, 1);
        check("busy_on_reject", bif.busy, 0);
        check("core_rst_on_reject", bif.core_rst, exp_core_rst);
        check("byte_ready_on_reject", bif.byte_ready, 0);
        tick();
        check("busy_after_reject", bif.busy, 0);
        check("err_sticky", bif.err, 1);
    endtask

    task automatic check_idle_reset();
        check("rst_byte_ready", bif.byte_ready, 0);
        check("rst_imem_we", bif.imem_we, 0);
        check("rst_imem_addr", bif.imem_addr, 0);
        check("rst_imem_wdata", bif.imem_wdata, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_done", bif.done, 0);
        check("rst_err", bif.err, 0);
        check("rst_core_rst", bif.core_rst, 1);
    endtask

    initial begin
        vec_t vecs[7];
        int   wr_before;
        logic [31:0] w;

        vecs[0] = '{len: 1,   rnd: 1'b0, mode: 0, poke: 1'b0, exp_err: 1'b0};
        vecs[1] = '{len: 3,   rnd: 1'b1, mode: 1, poke: 1'b0, exp_err: 1'b0};
        vecs[2] = '{len: 0,   rnd: 1'b0, mode: 1, poke: 1'b0, exp_err: 1'b1};
        vecs[3] = '{len: 200, rnd: 1'b0, mode: 1, poke: 1'b0, exp_err: 1'b1};
        vecs[4] = '{len: 2,   rnd: 1'b0, mode: 1, poke: 1'b0, exp_err: 1'b0};
        vecs[5] = '{len: 3,   rnd: 1'b1, mode: 1, poke: 1'b1, exp_err: 1'b0};
        vecs[6] = '{len: 128, rnd: 1'b0, mode: 2, poke: 1'b0, exp_err: 1'b0};

        rst            = 1'b1;
        bif.start      = 1'b0;
        bif.length     = 8'd0;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_reset();
        hold_on = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_err) do_reject(vecs[i].len);
            else do_load(vecs[i].len, vecs[i].rnd, vecs[i].mode, vecs[i].poke);
            repeat (2) tick();
        end

        // Reset after 6 bytes of a 4-word load
        wr_before  = n_writes;
        bif.start  = 1'b1;
        bif.length = 8'd4;
        tick();
        bif.start  = 1'b0;
        busy_win   = 1'b1;
        w = 32'd0;
        for (int k = 0; k < 6; k++) begin
            w[8*(k%4) +: 8] = 8'(8'hA0 + k);
            if (k == 3) sb_q.push_back('{addr: '0, data: w});
            send_byte(8'(8'hA0 + k), 1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy_win = 1'b0;
        exp_last_addr = '0;
        exp_last_data = 32'd0;
        exp_core_rst  = 1'b1;
        check_idle_reset();
        for (int c = 0; c < 20; c++) begin
            bif.byte_valid = 1'($urandom);
            bif.byte_data  = 8'($urandom);
            tick();
        end
        bif.byte_valid = 1'b0;
        check("writes_before_abort", n_writes - wr_before, 1);
        check("sb_empty_after_abort", sb_q.size(), 0);
        check("core_rst_held_after_abort", bif.core_rst, 1);

        // Fresh load after the abort must not see the stale partial word
        do_load(1, 1'b1, 1, 1'b0);
        repeat (3) tick();

        check("sb_empty_at_end", sb_q.size(), 0);
        check("done_pulse_count", n_done, loads_expected);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
